// File: rtl/mult_pkg.sv
// Shared constants for the 8x8 array multiplier.
// Optional build macro MULT_PIPE_EN adds a register in the middle of the
// adder array, which raises the latency from 2 to 3 clocks.
package mult_pkg;

    localparam int MULT_W    = 8;
    localparam int PROD_W    = 2 * MULT_W;

    // Last adder row that sits in front of the optional mid-array register
    localparam int SPLIT_ROW = 4;

`ifdef MULT_PIPE_EN
    localparam int MULT_LATENCY = 3;
`else
    localparam int MULT_LATENCY = 2;
`endif

endpackage

// File: rtl/mult_adder_row.sv
// One ripple-carry row of the array multiplier.
// The row adds the next partial-product row x to the shifted running sum y.
// It is built from WIDTH chained full adders.
module mult_adder_row #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar k = 0; k < WIDTH; k++) begin : g_fa
        assign sum[k]     = x[k] ^ y[k] ^ carry[k];
        assign carry[k+1] = (x[k] & y[k]) | (carry[k] & (x[k] ^ y[k]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/multiplier_ckt_8bit.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH registered array multiplier.
// The data path is: input registers -> AND partial products -> ripple adder
// rows -> output register. A valid bit travels alongside the data.
// It is fully pipelined, with no stall, and accepts one operand pair per clock.
// Optional build macro MULT_PIPE_EN adds a register after adder row SPLIT_ROW.
// That register holds the partial sum, the product bits already resolved, and
// the operand bits still needed by the later rows. Latency becomes 3 clocks.
module multiplier_ckt_8bit
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               in_vld,
    output logic [2*WIDTH-1:0] p,
    output logic               p_vld
);

    logic [WIDTH-1:0]           a_q;
    logic [WIDTH-1:0]           b_q;
    logic [MULT_LATENCY-1:0]    vld_pipe;

    logic [WIDTH-1:0]           pp_row [WIDTH];
    logic [WIDTH-1:0]           row_s  [WIDTH];
    logic                       row_c  [WIDTH];
    logic [SPLIT_ROW-1:0]       lo_early;

    // Signals seen by the rows after the split point. These signals are
    // registered copies when MULT_PIPE_EN is set, and plain wires otherwise.
    logic [WIDTH-1:0]           a_late;
    logic [WIDTH-1:SPLIT_ROW+1] b_late;
    logic [WIDTH-1:0]           s_late;
    logic                       c_late;
    logic [SPLIT_ROW-1:0]       lo_late;

    logic [2*WIDTH-1:0]         p_comb;

    // Stage 0: capture the operand pair on every edge, valid or not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= A;
            b_q <= B;
        end
    end

    // Valid shift chain. Its length matches the data latency, so p_vld lines up with p.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[MULT_LATENCY-2:0], in_vld};
        end
    end

    assign p_vld = vld_pipe[MULT_LATENCY-1];

    // Partial products pp[i][j] = a[j] & b[i]. Rows past the split use the late operands.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        if (i <= SPLIT_ROW) begin : g_early
            assign pp_row[i] = a_q & {WIDTH{b_q[i]}};
        end else begin : g_late
            assign pp_row[i] = a_late & {WIDTH{b_late[i]}};
        end
    end

    // Row 0 is the bare first partial product. No carry comes out of it.
    assign row_s[0] = pp_row[0];
    assign row_c[0] = 1'b0;

    // Each row adds the next partial product to the previous sum shifted
    // right by one. The bit shifted out is a finished product bit.
    for (genvar r = 1; r < WIDTH; r++) begin : g_row
        logic [WIDTH-1:0] y_in;

        if (r == SPLIT_ROW + 1) begin : g_after_split
            assign y_in = {c_late, s_late[WIDTH-1:1]};
        end else begin : g_chain
            assign y_in = {row_c[r-1], row_s[r-1][WIDTH-1:1]};
        end

        mult_adder_row #(
            .WIDTH (WIDTH)
        ) u_row (
            .x    (pp_row[r]),
            .y    (y_in),
            .cin  (1'b0),
            .sum  (row_s[r]),
            .cout (row_c[r])
        );
    end

    // Product bits already resolved before the split point
    for (genvar r = 0; r < SPLIT_ROW; r++) begin : g_lo
        assign lo_early[r] = row_s[r][0];
    end

`ifdef MULT_PIPE_EN
    logic [WIDTH-1:0]           a_mid;
    logic [WIDTH-1:SPLIT_ROW+1] b_mid;
    logic [WIDTH-1:0]           s_mid;
    logic                       c_mid;
    logic [SPLIT_ROW-1:0]       lo_mid;

    // Mid-array register: freeze the partial state after row SPLIT_ROW for one clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_mid  <= '0;
            b_mid  <= '0;
            s_mid  <= '0;
            c_mid  <= 1'b0;
            lo_mid <= '0;
        end else begin
            a_mid  <= a_q;
            b_mid  <= b_q[WIDTH-1:SPLIT_ROW+1];
            s_mid  <= row_s[SPLIT_ROW];
            c_mid  <= row_c[SPLIT_ROW];
            lo_mid <= lo_early;
        end
    end

    assign a_late  = a_mid;
    assign b_late  = b_mid;
    assign s_late  = s_mid;
    assign c_late  = c_mid;
    assign lo_late = lo_mid;
`else
    assign a_late  = a_q;
    assign b_late  = b_q[WIDTH-1:SPLIT_ROW+1];
    assign s_late  = row_s[SPLIT_ROW];
    assign c_late  = row_c[SPLIT_ROW];
    assign lo_late = lo_early;
`endif

    // Assemble the product. Low bits come out one per row. The last row
    // supplies the top WIDTH bits and the final carry.
    always_comb begin
        p_comb                          = '0;
        p_comb[SPLIT_ROW-1:0]           = lo_late;
        p_comb[SPLIT_ROW]               = s_late[0];
        for (int r = SPLIT_ROW + 1; r < WIDTH - 1; r++) begin
            p_comb[r] = row_s[r][0];
        end
        p_comb[2*WIDTH-2:WIDTH-1]       = row_s[WIDTH-1];
        p_comb[2*WIDTH-1]               = row_c[WIDTH-1];
    end

    // Output stage: register the finished product on every edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= '0;
        end else begin
            p <= p_comb;
        end
    end

endmodule

// File: tb/tb_multiplier_ckt_8bit.sv
// Directed testbench for multiplier_ckt_8bit.
// It also builds with MULT_PIPE_EN defined, in which case a 3-clock latency is expected.
`timescale 1ns/1ps
module tb_multiplier_ckt_8bit;
    import mult_pkg::*;

`ifdef MULT_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic              clk;
    logic              rst_n;
    logic [MULT_W-1:0] A;
    logic [MULT_W-1:0] B;
    logic              in_vld;
    logic [PROD_W-1:0] p;
    logic              p_vld;

    int checks = 0;
    int errors = 0;

    logic [7:0]  va [32];
    logic [7:0]  vb [32];
    logic        vv [32];
    logic [15:0] ve [32];

    multiplier_ckt_8bit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .B      (B),
        .in_vld (in_vld),
        .p      (p),
        .p_vld  (p_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_inputs(input logic [7:0] a, input logic [7:0] b, input logic v);
        A      = a;
        B      = b;
        in_vld = v;
    endtask

    task automatic set_vec(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic v, input logic [15:0] e);
        va[i] = a;
        vb[i] = b;
        vv[i] = v;
        ve[i] = e;
    endtask

    // Reset asserted asynchronously clears outputs; nothing valid appears while idle
    task automatic test_reset;
        drive_inputs(8'h00, 8'h00, 1'b0);
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (p !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_async_p got %h expected 0000", p);
        end
        checks++;
        if (p_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async_vld got %b expected 0", p_vld);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (p !== 16'h0000 || p_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_hold got p=%h vld=%b expected 0000/0", p, p_vld);
        end
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            checks++;
            if (p_vld !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_idle_vld[%0d] got %b expected 0", j, p_vld);
            end
        end
    endtask

    // Corner operands
    task automatic test_corners;
        int n;
        n = 4;
        set_vec(0, 8'd0,   8'd0,   1'b1, 16'h0000);
        set_vec(1, 8'd1,   8'd1,   1'b1, 16'h0001);
        set_vec(2, 8'd255, 8'd1,   1'b1, 16'h00FF);
        set_vec(3, 8'd255, 8'd255, 1'b1, 16'hFE01);
        for (int j = 0; j < n + LAT; j++) begin
            @(negedge clk);
            if (j >= LAT) begin
                checks++;
                if (p !== ve[j-LAT]) begin
                    errors++;
                    $display("[TB] FAIL corners_p[%0d] got %h expected %h", j-LAT, p, ve[j-LAT]);
                end
                checks++;
                if (p_vld !== vv[j-LAT]) begin
                    errors++;
                    $display("[TB] FAIL corners_vld[%0d] got %b expected %b", j-LAT, p_vld, vv[j-LAT]);
                end
            end
            if (j < n) drive_inputs(va[j], vb[j], vv[j]);
            else       drive_inputs(8'h00, 8'h00, 1'b0);
        end
    endtask

    // Bit patterns exercising long carry chains
    task automatic test_patterns;
        int n;
        n = 3;
        set_vec(0, 8'h55, 8'hAA, 1'b1, 16'h3872);
        set_vec(1, 8'hCC, 8'h33, 1'b1, 16'h28A4);
        set_vec(2, 8'h80, 8'h80, 1'b1, 16'h4000);
        for (int j = 0; j < n + LAT; j++) begin
            @(negedge clk);
            if (j >= LAT) begin
                checks++;
                if (p !== ve[j-LAT]) begin
                    errors++;
                    $display("[TB] FAIL patterns_p[%0d] got %h expected %h", j-LAT, p, ve[j-LAT]);
                end
                checks++;
                if (p_vld !== vv[j-LAT]) begin
                    errors++;
                    $display("[TB] FAIL patterns_vld[%0d] got %b expected %b", j-LAT, p_vld, vv[j-LAT]);
                end
            end
            if (j < n) drive_inputs(va[j], vb[j], vv[j]);
            else       drive_inputs(8'h00, 8'h00, 1'b0);
        end
    endtask

    // Invalid slot in the middle: data still flows, valid shows the gap
    task automatic test_valid_gaps;
        int n;
        n = 3;
        set_vec(0, 8'h12, 8'h34, 1'b1, 16'h03A8);
        set_vec(1, 8'h56, 8'h78, 1'b0, 16'h2850);
        set_vec(2, 8'h9A, 8'hBC, 1'b1, 16'h7118);
        for (int j = 0; j < n + LAT; j++) begin
            @(negedge clk);
            if (j >= LAT) begin
                checks++;
                if (p !== ve[j-LAT]) begin
                    errors++;
                    $display("[TB] FAIL gaps_p[%0d] got %h expected %h", j-LAT, p, ve[j-LAT]);
                end
                checks++;
                if (p_vld !== vv[j-LAT]) begin
                    errors++;
                    $display("[TB] FAIL gaps_vld[%0d] got %b expected %b", j-LAT, p_vld, vv[j-LAT]);
                end
            end
            if (j < n) drive_inputs(va[j], vb[j], vv[j]);
            else       drive_inputs(8'h00, 8'h00, 1'b0);
        end
    endtask

    // One random pair every clock: products appear in order with none dropped
    task automatic test_back_to_back;
        int n;
        logic [7:0] a;
        logic [7:0] b;
        n = 20;
        for (int i = 0; i < n; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            set_vec(i, a, b, 1'b1, {8'h00, a} * {8'h00, b});
        end
        for (int j = 0; j < n + LAT; j++) begin
            @(negedge clk);
            if (j >= LAT) begin
                checks++;
                if (p !== ve[j-LAT]) begin
                    errors++;
                    $display("[TB] FAIL b2b_p[%0d] got %h expected %h", j-LAT, p, ve[j-LAT]);
                end
                checks++;
                if (p_vld !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_vld[%0d] got %b expected 1", j-LAT, p_vld);
                end
            end
            if (j < n) drive_inputs(va[j], vb[j], vv[j]);
            else       drive_inputs(8'h00, 8'h00, 1'b0);
        end
    endtask

    // Reset in the middle of a stream discards in-flight products
    task automatic test_reset_mid_stream;
        int n;
        for (int j = 0; j < LAT + 1; j++) begin
            @(negedge clk);
            drive_inputs(8'hFF, 8'hFF, 1'b1);
        end
        @(negedge clk);
        checks++;
        if (p !== 16'hFE01 || p_vld !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_pre got p=%h vld=%b expected FE01/1", p, p_vld);
        end
        #2;
        rst_n = 1'b0;
        drive_inputs(8'h00, 8'h00, 1'b0);
        #1;
        checks++;
        if (p !== 16'h0000 || p_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_async got p=%h vld=%b expected 0000/0", p, p_vld);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 3;
        set_vec(0, 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        set_vec(1, 8'h03, 8'h05, 1'b1, 16'h000F);
        set_vec(2, 8'h00, 8'h00, 1'b0, 16'h0000);
        for (int j = 0; j < n + LAT; j++) begin
            @(negedge clk);
            if (j < LAT) begin
                checks++;
                if (p !== 16'h0000 || p_vld !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL midrst_flush[%0d] got p=%h vld=%b expected 0000/0", j, p, p_vld);
                end
            end else begin
                checks++;
                if (p !== ve[j-LAT]) begin
                    errors++;
                    $display("[TB] FAIL midrst_p[%0d] got %h expected %h", j-LAT, p, ve[j-LAT]);
                end
                checks++;
                if (p_vld !== vv[j-LAT]) begin
                    errors++;
                    $display("[TB] FAIL midrst_vld[%0d] got %b expected %b", j-LAT, p_vld, vv[j-LAT]);
                end
            end
            if (j < n) drive_inputs(va[j], vb[j], vv[j]);
            else       drive_inputs(8'h00, 8'h00, 1'b0);
        end
    endtask

    // Every A value against a handful of B values, checked against a reference A*B
    task automatic test_sweep;
        logic [7:0] bsel [5];
        int total;
        int k;
        logic [7:0] a;
        logic [7:0] b;
        logic [15:0] e;
        bsel[0] = 8'h01;
        bsel[1] = 8'h7F;
        bsel[2] = 8'h80;
        bsel[3] = 8'hFF;
        bsel[4] = 8'hA5;
        total = 256 * 5;
        for (int j = 0; j < total + LAT; j++) begin
            @(negedge clk);
            if (j >= LAT) begin
                k = j - LAT;
                a = 8'(k / 5);
                b = bsel[k % 5];
                e = {8'h00, a} * {8'h00, b};
                checks++;
                if (p !== e || p_vld !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL sweep %h*%h got p=%h vld=%b expected %h/1", a, b, p, p_vld, e);
                end
            end
            if (j < total) drive_inputs(8'(j / 5), bsel[j % 5], 1'b1);
            else           drive_inputs(8'h00, 8'h00, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        drive_inputs(8'h00, 8'h00, 1'b0);
        test_reset();
        test_corners();
        test_patterns();
        test_valid_gaps();
        test_back_to_back();
        test_reset_mid_stream();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
